// File: rtl/memory_responder.sv
// Byte-enabled single-port SRAM model with a fixed-latency pipelined read path.
// After every reset the array is zero-filled one word per cycle before requests are accepted.
module memory_responder #(
  parameter int DATA_FIELD_WIDTH = 64,
  parameter int BYTE             = 8,
  parameter int ADDR_FIELD_WIDTH = 32,
  parameter int DEPTH_LOG2       = 10,
  parameter int READ_LATENCY     = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req,
  input  logic                             write,
  input  logic [DATA_FIELD_WIDTH/BYTE-1:0] we,
  input  logic [ADDR_FIELD_WIDTH-1:0]      addr,
  input  logic [DATA_FIELD_WIDTH-1:0]      data,
  output logic [DATA_FIELD_WIDTH-1:0]      q,
  output logic                             q_valid,
  output logic                             ready
);

  localparam int LANES    = DATA_FIELD_WIDTH / BYTE;
  localparam int ADDR_LSB = $clog2(LANES);
  localparam int DEPTH    = 1 << DEPTH_LOG2;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t                      state;
  state_t                      next_state;
  logic [DEPTH_LOG2-1:0]       fill_ptr;
  logic [DEPTH_LOG2-1:0]       idx;
  logic                        fill_en;
  logic                        wr_en;
  logic                        rd_en;
  logic [DATA_FIELD_WIDTH-1:0] mem [DEPTH];
  logic [DATA_FIELD_WIDTH-1:0] pipe_data [READ_LATENCY];
  logic [READ_LATENCY-1:0]     pipe_vld;
  logic                        unused_addr;

  // Upper address bits alias and sub-word bits are don't-care.
  assign idx         = addr[ADDR_LSB +: DEPTH_LOG2];
  assign unused_addr = ^addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    ready      = 1'b0;
    fill_en    = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    unique case (state)
      INIT: begin
        fill_en = !reset;
        if (&fill_ptr) begin
          next_state = RUN;
        end
      end
      RUN: begin
        ready = 1'b1;
        wr_en = req && write && !reset;
        rd_en = req && !write && !reset;
      end
      default: next_state = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_ptr <= '0;
    end else if (fill_en) begin
      fill_ptr <= fill_ptr + DEPTH_LOG2'(1);
    end
  end

  // The array itself has no reset; the fill engine clears it instead.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      mem[fill_ptr] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (we[i]) begin
          mem[idx][i*BYTE +: BYTE] <= data[i*BYTE +: BYTE];
        end
      end
    end
  end

  // Data stages only advance behind a valid token, so the last stage holds
  // the most recent response while q_valid is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= rd_en;
      if (rd_en) begin
        pipe_data[0] <= mem[idx];
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        if (pipe_vld[i-1]) begin
          pipe_data[i] <= pipe_data[i-1];
        end
      end
    end
  end

  assign q       = pipe_data[READ_LATENCY-1];
  assign q_valid = pipe_vld[READ_LATENCY-1];

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: three instances (read latency 2, 1 and 8) share one
// stimulus stream; a scoreboard queue holds every expected read response.
module tb_memory_responder;

  localparam int LAT [3] = '{2, 1, 8};

  typedef struct {
    logic        wr;
    logic [7:0]  we;
    logic [31:0] addr;
    logic [63:0] data;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    int          dut;
    int          due;
    logic [63:0] data;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        write = 1'b0;
  logic [7:0]  we = '0;
  logic [31:0] addr = '0;
  logic [63:0] data = '0;
  logic [63:0] q_d [3];
  logic        q_valid_d [3];
  logic        ready_d [3];

  int          cyc = 0;
  int          check_cnt = 0;
  int          pass_cnt = 0;
  int          qv_seen = 0;
  logic        bench_run = 1'b0;
  logic [63:0] model_mem [1024];
  sb_t         sb [$];
  vec_t        tbl [14];

  memory_responder #(.READ_LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .req(req), .write(write), .we(we), .addr(addr), .data(data),
    .q(q_d[0]), .q_valid(q_valid_d[0]), .ready(ready_d[0])
  );
  memory_responder #(.READ_LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .req(req), .write(write), .we(we), .addr(addr), .data(data),
    .q(q_d[1]), .q_valid(q_valid_d[1]), .ready(ready_d[1])
  );
  memory_responder #(.READ_LATENCY(8)) u_l8 (
    .clk(clk), .reset(reset), .req(req), .write(write), .we(we), .addr(addr), .data(data),
    .q(q_d[2]), .q_valid(q_valid_d[2]), .ready(ready_d[2])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Responses are matched per instance, oldest first, against due cycle and data.
  always @(negedge clk) begin
    int idx;
    if (q_valid_d[0] || q_valid_d[1] || q_valid_d[2]) qv_seen++;
    for (int k = 0; k < 3; k++) begin
      idx = -1;
      for (int i = 0; i < sb.size(); i++) begin
        if (sb[i].dut == k) begin
          idx = i;
          break;
        end
      end
      if (q_valid_d[k]) begin
        if (idx < 0) begin
          checkOutput($sformatf("unexpected_q_valid_L%0d", LAT[k]), 64'd1, 64'd0);
        end else begin
          checkOutput($sformatf("q_valid_timing_L%0d", LAT[k]), 64'(cyc), 64'(sb[idx].due));
          checkOutput($sformatf("q_data_L%0d", LAT[k]), q_d[k], sb[idx].data);
          sb.delete(idx);
        end
      end else if (idx >= 0 && sb[idx].due <= cyc) begin
        checkOutput($sformatf("missing_q_valid_L%0d", LAT[k]), 64'd0, 64'd1);
        sb.delete(idx);
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic w, input logic [7:0] be,
                               input logic [31:0] a, input logic [63:0] d,
                               input logic has_exp, input logic [63:0] e);
    logic [63:0] ev;
    @(posedge clk);
    #1;
    req   = r;
    write = w;
    we    = be;
    addr  = a;
    data  = d;
    if (bench_run && r) begin
      if (w) begin
        for (int i = 0; i < 8; i++) begin
          if (be[i]) model_mem[a[12:3]][i*8 +: 8] = d[i*8 +: 8];
        end
      end else begin
        ev = has_exp ? e : model_mem[a[12:3]];
        for (int k = 0; k < 3; k++) begin
          sb.push_back('{dut: k, due: cyc + LAT[k], data: ev});
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 64'h0, 1'b0, 64'h0);
  endtask

  task automatic doReset(input logic rd_during);
    @(posedge clk);
    #1;
    reset = 1'b1;
    req   = rd_during;
    write = 1'b0;
    addr  = 32'h40;
    bench_run = 1'b0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due > cyc) sb.delete(i);
    end
    for (int i = 0; i < 1024; i++) model_mem[i] = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    req   = 1'b0;
    checkOutput("reset_q", q_d[0], 64'h0);
    checkOutput("reset_q_valid", 64'(q_valid_d[0]), 64'd0);
    checkOutput("reset_ready", 64'(ready_d[0]), 64'd0);
  endtask

  task automatic waitReady();
    int n = 0;
    int seen0 = qv_seen;
    while (!ready_d[0] && n < 1100) begin
      if (n == 600) applyStimulus(1'b1, 1'b1, 8'hFF, 32'h8, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0);
      else if (n == 601) applyStimulus(1'b1, 1'b0, 8'h00, 32'h8, 64'h0, 1'b0, 64'h0);
      else applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 64'h0, 1'b0, 64'h0);
      n++;
      if (n == 12) checkOutput("no_q_valid_after_reset", 64'(qv_seen - seen0), 64'd0);
      if (n == 601) checkOutput("ready_low_in_init", 64'(ready_d[0]), 64'd0);
    end
    checkOutput("init_cycles", 64'(n), 64'd1024);
    checkOutput("ready_L1", 64'(ready_d[1]), 64'd1);
    checkOutput("ready_L8", 64'(ready_d[2]), 64'd1);
    bench_run = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] last_val;
    logic [31:0] a;

    tbl[0]  = '{1'b1, 8'hFF, 32'h0000_0040, 64'h1122_3344_5566_7788, 64'h0};
    tbl[1]  = '{1'b0, 8'h00, 32'h0000_0040, 64'h0, 64'h1122_3344_5566_7788};
    tbl[2]  = '{1'b1, 8'h0F, 32'h0000_0040, 64'hAAAA_AAAA_BBBB_BBBB, 64'h0};
    tbl[3]  = '{1'b0, 8'h00, 32'h0000_0040, 64'h0, 64'h1122_3344_BBBB_BBBB};
    tbl[4]  = '{1'b1, 8'hFF, 32'h0000_2040, 64'hCAFE_F00D_DEAD_BEEF, 64'h0};
    tbl[5]  = '{1'b0, 8'h00, 32'h0000_0040, 64'h0, 64'hCAFE_F00D_DEAD_BEEF};
    tbl[6]  = '{1'b0, 8'h00, 32'h0000_0047, 64'h0, 64'hCAFE_F00D_DEAD_BEEF};
    tbl[7]  = '{1'b1, 8'h00, 32'h0000_0080, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    tbl[8]  = '{1'b0, 8'h00, 32'h0000_0080, 64'h0, 64'h0};
    tbl[9]  = '{1'b1, 8'h81, 32'h0000_0088, 64'h0102_0304_0506_0708, 64'h0};
    tbl[10] = '{1'b0, 8'h00, 32'h0000_0088, 64'h0, 64'h0100_0000_0000_0008};
    tbl[11] = '{1'b0, 8'hFF, 32'h0000_0100, 64'hDEAD_DEAD_DEAD_DEAD, 64'h0};
    tbl[12] = '{1'b1, 8'hF0, 32'h0000_0040, 64'h5555_5555_6666_6666, 64'h0};
    tbl[13] = '{1'b0, 8'h00, 32'hFFFF_2040, 64'h0, 64'h5555_5555_DEAD_BEEF};

    doReset(1'b1);
    waitReady();
    applyStimulus(1'b1, 1'b0, 8'h00, 32'h8, 64'h0, 1'b1, 64'h0);
    applyStimulus(1'b1, 1'b0, 8'h00, 32'h123, 64'h0, 1'b1, 64'h0);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b1, tbl[i].wr, tbl[i].we, tbl[i].addr, tbl[i].data, !tbl[i].wr, tbl[i].exp);
    end

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 8'hFF, 32'(i * 8), {32'(i + 1), $urandom}, 1'b0, 64'h0);
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h00, 32'(i * 8), 64'h0, 1'b0, 64'h0);
    end
    last_val = model_mem[7];
    idle(12);
    checkOutput("hold_q_L2", q_d[0], last_val);
    checkOutput("hold_q_L8", q_d[2], last_val);
    checkOutput("hold_q_valid_low", 64'(q_valid_d[0]), 64'd0);

    for (int i = 0; i < 200; i++) begin
      a = (32'($urandom_range(0, 15)) << 3) | (32'($urandom_range(0, 3)) << 13) | 32'($urandom_range(0, 7));
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, 8'($urandom),
                    a, {$urandom, $urandom}, 1'b0, 64'h0);
    end
    idle(12);

    applyStimulus(1'b1, 1'b0, 8'h00, 32'h40, 64'h0, 1'b0, 64'h0);
    applyStimulus(1'b1, 1'b0, 8'h00, 32'h88, 64'h0, 1'b0, 64'h0);
    doReset(1'b1);
    waitReady();
    applyStimulus(1'b1, 1'b0, 8'h00, 32'h40, 64'h0, 1'b1, 64'h0);
    applyStimulus(1'b1, 1'b0, 8'h00, 32'h88, 64'h0, 1'b1, 64'h0);
    idle(12);

    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
